vs4x400_search_sched: RTL and testbench
=======================================

Name: vs4x400_search_sched

Overview:
- Round-robin scheduler that shares one vs4x400 search core among NUM_REQ host requesters.
- Each requester submits a job descriptor (vector_count, dim_size). The scheduler validates it, programs the core, pulses start_search and tracks the core's busy handshake.
- On completion it captures max_score/winner_id and returns a tagged response on a single shared response channel.
- It sits between the host/DMA request fabric and the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_VEC, 400, largest legal vector_count.
- START_TIMEOUT, 16, cycles allowed for core busy to rise after start_search.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot; grant and acceptance of the descriptor.
- req_vec_count  in  10*NUM_REQ  packed per-requester vector_count; slice i belongs to requester i.
- req_dim_size  in  8*NUM_REQ  packed per-requester dim_size.
- core_start  out  1  drives core start_search.
- core_vector_count  out  10  drives core vector_count.
- core_dim_size  out  8  drives core dim_size.
- core_busy  in  1  core busy.
- core_max_score  in  32 signed  core max_score.
- core_winner_id  in  8  core winner_id.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_req_id  out  3  index of the requester the response belongs to.
- resp_score  out  32 signed  captured max_score.
- resp_winner  out  8  captured winner_id.
- resp_err  out  2  0 = ok, 1 = bad descriptor, 2 = start timeout.
- jobs_done  out  16  count of completed responses; wraps at 0xFFFF->0.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - state IDLE; rr_ptr 0.
  - req_ready 0, core_start 0, core_vector_count 0, core_dim_size 0.
  - resp_valid 0, resp_req_id 0, resp_score 0, resp_winner 8'hFF, resp_err 0.
  - jobs_done 0.
- Reset mid-job abandons the job with no response. The core is reset by its own reset.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid, select the first asserted index searching from rr_ptr upward with wrap.
  - Assert req_ready[g] for exactly that one cycle.
  - Latch g, the vec_count slice and the dim_size slice. core_vector_count/core_dim_size take the latched values and stay stable until the next grant.
  - Descriptor is legal iff vec_count in 1..MAX_VEC, dim_size != 0 and dim_size[2:0] == 0.
  - Legal -> ISSUE. Illegal -> RESP with resp_err=1, resp_score=0, resp_winner=8'hFF; the core is never started.
- ISSUE: core_start=1 for exactly one cycle -> WAIT_BUSY. Clear the timeout counter.
- WAIT_BUSY:
  - core_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter. When it reaches START_TIMEOUT-1 -> RESP with resp_err=2, resp_score=0, resp_winner=8'hFF.
  - core_busy is expected high the cycle after core_start.
- WAIT_DONE: on the first cycle core_busy=0, capture core_max_score and core_winner_id into resp_score/resp_winner, resp_err=0 -> RESP. No timeout in this state.
- RESP:
  - resp_valid=1. resp_* fields are held stable until resp_ready is sampled high.
  - On the handshake: resp_valid drops next cycle, jobs_done increments, rr_ptr = (g+1) mod NUM_REQ, state -> IDLE.
  - Minimum gap between back-to-back grants: 1 IDLE cycle.
- Latency, legal job: grant cycle G; core_start at G+1; busy sampled high at G+2 at the earliest; response appears the cycle after busy is first seen low.
- Fairness: after requester g is served, every other requester with req_valid held is granted before g again.
- req_valid deasserted while not granted: no effect.
- A requester holding req_valid through its own response may be granted again only after the round-robin pass.
- winner_id 8'hFF from the core (no vector beat the initial minimum) passes through unchanged with resp_err=0.

Test Plan:
- Single job: req0 with vec_count=3, dim_size=16; core model returns busy high for 6 cycles, score=1234, winner=2 -> one req_ready[0] pulse, one core_start pulse, resp {id 0, score 1234, winner 2, err 0}, jobs_done=1.
- Round-robin: req0, req1 and req3 all valid and held -> grant order 0,1,3,0; no grant is issued while any job is outstanding.
- Bad descriptors: dim_size=12; then vec_count=0; then vec_count=401 -> each gives resp_err=1, winner 8'hFF, core_start never asserted.
- Start timeout: core_busy tied low -> resp_err=2 exactly START_TIMEOUT cycles after core_start; scheduler then returns to IDLE and accepts req2.
- Response backpressure: resp_ready low for 10 cycles -> resp fields stable, no new grant, jobs_done unchanged until the handshake.
- Reset mid-WAIT_DONE: reset_n low for 2 cycles -> all outputs at reset values immediately, no response emitted, and the next job proceeds normally.

Source files
------------

// File: rtl/vs4x400_search_sched.sv
// Round-robin scheduler that shares one vs4x400 search core among NUM_REQ requesters.
// Validates each descriptor, starts the core, tracks busy, and returns a tagged response.
module vs4x400_search_sched #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_VEC       = 400,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [10*NUM_REQ-1:0]  req_vec_count,
  input  logic [8*NUM_REQ-1:0]   req_dim_size,
  output logic                   core_start,
  output logic [9:0]             core_vector_count,
  output logic [7:0]             core_dim_size,
  input  logic                   core_busy,
  input  logic signed [31:0]     core_max_score,
  input  logic [7:0]             core_winner_id,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [2:0]             resp_req_id,
  output logic signed [31:0]     resp_score,
  output logic [7:0]             resp_winner,
  output logic [1:0]             resp_err,
  output logic [15:0]            jobs_done,
  output logic [2:0]             dbg_state
);

  localparam int CW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_rr_ptr;
  logic [2:0]          r_gnt;
  logic [CW-1:0]       r_cnt;
  logic [9:0]          r_core_vec;
  logic [7:0]          r_core_dim;
  logic [2:0]          r_resp_req_id;
  logic signed [31:0]  r_resp_score;
  logic [7:0]          r_resp_winner;
  logic [1:0]          r_resp_err;
  logic [15:0]         r_jobs_done;

  logic [7:0]          w_valid8;
  logic [9:0]          w_vec_arr [8];
  logic [7:0]          w_dim_arr [8];
  logic                w_any;
  logic [2:0]          w_gnt;
  logic [3:0]          w_sum;
  logic [9:0]          w_vec;
  logic [7:0]          w_dim;
  logic [7:0]          w_onehot;
  logic                w_legal;
  logic                w_timeout;

  // Handshakes: a descriptor is accepted in the cycle req_valid[g] & req_ready[g]
  // are both high; a response is consumed in the cycle resp_valid & resp_ready.
  always_comb begin
    w_valid8 = '0;
    for (int i = 0; i < 8; i++) begin
      w_vec_arr[i] = '0;
      w_dim_arr[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_valid8[i]  = req_valid[i];
      w_vec_arr[i] = req_vec_count[i*10 +: 10];
      w_dim_arr[i] = req_dim_size[i*8 +: 8];
    end
  end

  // First asserted requester at or after r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(i);
      if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
      if (!w_any && w_valid8[w_sum[2:0]]) begin
        w_any = 1'b1;
        w_gnt = w_sum[2:0];
      end
    end
  end

  assign w_vec     = w_vec_arr[w_gnt];
  assign w_dim     = w_dim_arr[w_gnt];
  assign w_onehot  = 8'd1 << w_gnt;
  assign w_legal   = (w_vec != 10'd0) && (w_vec <= 10'(MAX_VEC)) &&
                     (w_dim != 8'd0) && (w_dim[2:0] == 3'd0);
  assign w_timeout = (r_cnt == CW'(START_TIMEOUT - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any) w_next = w_legal ? S_ISSUE : S_RESP;
      S_ISSUE:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (core_busy)      w_next = S_WAIT_DONE;
        else if (w_timeout) w_next = S_RESP;
      end
      S_WAIT_DONE: if (!core_busy) w_next = S_RESP;
      S_RESP:      if (resp_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr      <= '0;
      r_gnt         <= '0;
      r_cnt         <= '0;
      r_core_vec    <= '0;
      r_core_dim    <= '0;
      r_resp_req_id <= '0;
      r_resp_score  <= '0;
      r_resp_winner <= 8'hFF;
      r_resp_err    <= '0;
      r_jobs_done   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt         <= w_gnt;
          r_core_vec    <= w_vec;
          r_core_dim    <= w_dim;
          r_resp_req_id <= w_gnt;
          if (!w_legal) begin
            r_resp_err    <= 2'd1;
            r_resp_score  <= '0;
            r_resp_winner <= 8'hFF;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT_BUSY: if (!core_busy) begin
          r_cnt <= r_cnt + CW'(1);
          if (w_timeout) begin
            r_resp_err    <= 2'd2;
            r_resp_score  <= '0;
            r_resp_winner <= 8'hFF;
          end
        end
        S_WAIT_DONE: if (!core_busy) begin
          r_resp_err    <= 2'd0;
          r_resp_score  <= core_max_score;
          r_resp_winner <= core_winner_id;
        end
        S_RESP: if (resp_ready) begin
          r_jobs_done <= r_jobs_done + 16'd1;
          r_rr_ptr    <= (r_gnt == 3'(NUM_REQ - 1)) ? 3'd0 : r_gnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Grant is combinational from IDLE; qualified by reset_n so it reads 0 in reset.
  assign req_ready         = (r_state == S_IDLE && w_any && reset_n) ? w_onehot[NUM_REQ-1:0] : '0;
  assign core_start        = (r_state == S_ISSUE);
  assign resp_valid        = (r_state == S_RESP);
  assign core_vector_count = r_core_vec;
  assign core_dim_size     = r_core_dim;
  assign resp_req_id       = r_resp_req_id;
  assign resp_score        = r_resp_score;
  assign resp_winner       = r_resp_winner;
  assign resp_err          = r_resp_err;
  assign jobs_done         = r_jobs_done;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_vs4x400_search_sched.sv
// Bench for vs4x400_search_sched: behavioural core model, round-robin/legality reference
// model and an expected-response queue.
module tb_vs4x400_search_sched;
  localparam int NUM_REQ = 4;
  localparam int MAX_VEC = 400;
  localparam int START_TIMEOUT = 16;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [10*NUM_REQ-1:0] req_vec_count;
  logic [8*NUM_REQ-1:0]  req_dim_size;
  logic                  core_start;
  logic [9:0]            core_vector_count;
  logic [7:0]            core_dim_size;
  logic                  core_busy;
  logic signed [31:0]    core_max_score;
  logic [7:0]            core_winner_id;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [2:0]            resp_req_id;
  logic signed [31:0]    resp_score;
  logic [7:0]            resp_winner;
  logic [1:0]            resp_err;
  logic [15:0]           jobs_done;
  logic [2:0]            dbg_state;

  vs4x400_search_sched #(.NUM_REQ(NUM_REQ), .MAX_VEC(MAX_VEC), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec_count(req_vec_count), .req_dim_size(req_dim_size),
    .core_start(core_start), .core_vector_count(core_vector_count), .core_dim_size(core_dim_size),
    .core_busy(core_busy), .core_max_score(core_max_score), .core_winner_id(core_winner_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_req_id(resp_req_id),
    .resp_score(resp_score), .resp_winner(resp_winner), .resp_err(resp_err),
    .jobs_done(jobs_done), .dbg_state(dbg_state)
  );

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          n_total = 0;
  int          n_bad   = 0;
  logic [44:0] exp_q[$];
  int          m_ptr   = 0;
  logic [15:0] m_jobs  = '0;
  logic [9:0]  d_vc [NUM_REQ];
  logic [7:0]  d_dim [NUM_REQ];

  // Core model controls and observations
  logic               cm_dead  = 1'b0;
  int                 cm_len   = 1;
  logic signed [31:0] cm_score = '0;
  logic [7:0]         cm_win   = '0;
  int                 n_start  = 0;
  int                 t_start  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return 0;
  endfunction

  function automatic bit model_legal(input int vc, input int dim);
    return (vc >= 1) && (vc <= MAX_VEC) && (dim != 0) && (dim % 8 == 0);
  endfunction

  // Core: busy rises the cycle after start, stays high cm_len cycles, then results appear.
  initial begin
    int  left;
    bit  pend;
    left = 0;
    pend = 0;
    core_busy = 1'b0;
    core_max_score = '0;
    core_winner_id = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        core_busy = 1'b0;
        pend = 0;
        left = 0;
      end else if (pend) begin
        pend = 0;
        core_busy = 1'b1;
        left = cm_len;
      end else if (core_busy) begin
        left--;
        if (left == 0) begin
          core_busy = 1'b0;
          core_max_score = cm_score;
          core_winner_id = cm_win;
        end
      end
      if (core_start) begin
        n_start++;
        t_start = cyc;
        if (!cm_dead) pend = 1;
      end
    end
  end

  // Driver tasks
  task automatic drive_desc();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vec_count[i*10 +: 10] = d_vc[i];
      req_dim_size[i*8 +: 8]    = d_dim[i];
    end
  endtask

  task automatic run_job(input logic [NUM_REQ-1:0] mask, input int bp);
    int g, n, t_g, s0, e_lat;
    bit legal;
    logic [1:0] e_err;
    logic signed [31:0] e_sc;
    logic [7:0] e_w;
    logic [44:0] got_r;
    g = model_pick(mask, m_ptr);
    legal = model_legal(int'(d_vc[g]), int'(d_dim[g]));
    if (!legal)       begin e_err = 2'd1; e_lat = 1; end
    else if (cm_dead) begin e_err = 2'd2; e_lat = 1 + START_TIMEOUT; end
    else              begin e_err = 2'd0; e_lat = 3 + cm_len; end
    e_sc = (e_err == 2'd0) ? cm_score : 32'sd0;
    e_w  = (e_err == 2'd0) ? cm_win : 8'hFF;
    exp_q.push_back({3'(g), e_sc, e_w, e_err});
    s0 = n_start;
    @(posedge clk); #1;
    drive_desc();
    req_valid = mask;
    #2;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(posedge clk); #3;
      n++;
    end
    chk("grant", 64'(req_ready), 64'(1 << g));
    t_g = cyc;
    @(posedge clk); #1;
    req_valid = mask & ~NUM_REQ'(1 << g);
    #2;
    chk("core_vec", 64'(core_vector_count), 64'(d_vc[g]));
    chk("core_dim", 64'(core_dim_size), 64'(d_dim[g]));
    n = 0;
    while (!resp_valid && n < 60) begin
      chk("no_grant_outstanding", 64'(req_ready), 64'(0));
      @(posedge clk); #3;
      n++;
    end
    chk("resp_latency", 64'(cyc - t_g), 64'(e_lat));
    chk("core_start_count", 64'(n_start - s0), 64'(legal ? 1 : 0));
    if (legal) chk("core_start_cycle", 64'(t_start), 64'(t_g + 1));
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #3;
      chk("bp_hold", 64'({resp_valid, resp_req_id, resp_score, resp_winner, resp_err}),
          64'({1'b1, exp_q[0]}));
      chk("bp_jobs", 64'(jobs_done), 64'(m_jobs));
      chk("bp_no_grant", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_valid  = '0;
    #2;
    got_r = {resp_req_id, resp_score, resp_winner, resp_err};
    chk("resp_valid", 64'(resp_valid), 64'(1));
    chk("resp", 64'(got_r), 64'(exp_q.pop_front()));
    @(posedge clk); #1;
    resp_ready = 1'b0;
    #2;
    m_jobs++;
    m_ptr = (g + 1) % NUM_REQ;
    chk("resp_drop", 64'(resp_valid), 64'(0));
    chk("jobs_done", 64'(jobs_done), 64'(m_jobs));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_core_start"}, 64'(core_start), 64'(0));
    chk({tag, "_core_vec"}, 64'(core_vector_count), 64'(0));
    chk({tag, "_core_dim"}, 64'(core_dim_size), 64'(0));
    chk({tag, "_resp"}, 64'({resp_valid, resp_req_id, resp_score, resp_winner, resp_err}),
        64'({1'b0, 3'd0, 32'd0, 8'hFF, 2'd0}));
    chk({tag, "_jobs"}, 64'(jobs_done), 64'(0));
  endtask

  // Requesters 0,1,3 held valid with an always-ready consumer.
  task automatic rr_test();
    int n, ngr, g, last_g;
    bit outstanding;
    logic [NUM_REQ-1:0] mask;
    mask = 4'b1011;
    for (int i = 0; i < NUM_REQ; i++) begin d_vc[i] = 10'd5; d_dim[i] = 8'd8; end
    cm_dead = 1'b0; cm_len = 2; cm_score = 32'sd77; cm_win = 8'd9;
    @(posedge clk); #1;
    drive_desc();
    req_valid = mask;
    resp_ready = 1'b1;
    #2;
    n = 0; ngr = 0; last_g = 0; outstanding = 0;
    while (n < 300 && (ngr < 4 || outstanding)) begin
      if (req_ready != '0) begin
        g = model_pick(mask, m_ptr);
        chk("rr_grant", 64'(req_ready), 64'(1 << g));
        chk("rr_grant_while_busy", 64'(outstanding), 64'(0));
        outstanding = 1; last_g = g; ngr++;
      end
      if (resp_valid) begin
        chk("rr_resp", 64'({resp_req_id, resp_score, resp_winner, resp_err}),
            64'({3'(last_g), 32'sd77, 8'd9, 2'd0}));
        chk("rr_jobs", 64'(jobs_done), 64'(m_jobs));
        outstanding = 0;
        m_ptr = (last_g + 1) % NUM_REQ;
        m_jobs++;
      end
      @(posedge clk); #1;
      if (ngr >= 4) req_valid = '0;
      #2;
      n++;
    end
    chk("rr_grant_count", 64'(ngr), 64'(4));
    resp_ready = 1'b0;
  endtask

  initial begin
    int g;
    reset_n = 1'b0;
    req_valid = '1;
    resp_ready = 1'b0;
    req_vec_count = '0;
    req_dim_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin d_vc[i] = 10'd1; d_dim[i] = 8'd8; end
    repeat (3) @(posedge clk);
    #3;
    check_reset_values("reset");
    @(posedge clk); #1;
    req_valid = '0;
    reset_n = 1'b1;
    #2;

    rr_test();

    // Single job
    d_vc[0] = 10'd3; d_dim[0] = 8'd16;
    cm_dead = 1'b0; cm_len = 6; cm_score = 32'sd1234; cm_win = 8'd2;
    run_job(4'b0001, 0);

    // Bad descriptors
    d_vc[0] = 10'd3;   d_dim[0] = 8'd12; run_job(4'b0001, 1);
    d_vc[0] = 10'd0;   d_dim[0] = 8'd16; run_job(4'b0001, 0);
    d_vc[0] = 10'd401; d_dim[0] = 8'd16; run_job(4'b0001, 2);
    d_vc[0] = 10'd400; d_dim[0] = 8'd8;  run_job(4'b0001, 0);

    // Start timeout, then req2 is accepted
    cm_dead = 1'b1;
    d_vc[0] = 10'd7; d_dim[0] = 8'd32;
    run_job(4'b0001, 0);
    cm_dead = 1'b0; cm_len = 3; cm_score = -32'sd5; cm_win = 8'hFF;
    d_vc[2] = 10'd1; d_dim[2] = 8'd8;
    run_job(4'b0100, 0);

    // Backpressure with other requesters pending
    cm_len = 4; cm_score = 32'sd99; cm_win = 8'd17;
    d_vc[1] = 10'd100; d_dim[1] = 8'd64;
    run_job(4'b1110, 10);

    // Reset while the core is busy
    d_vc[1] = 10'd50; d_dim[1] = 8'd24;
    cm_len = 20;
    @(posedge clk); #1;
    drive_desc();
    req_valid = 4'b0010;
    #2;
    g = 0;
    while (req_ready == '0 && g < 20) begin @(posedge clk); #3; g++; end
    chk("rst_job_grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1; req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_ptr = 0;
    m_jobs = '0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #3;
      chk("post_reset_no_resp", 64'({resp_valid, core_start}), 64'(0));
    end
    cm_len = 2; cm_score = 32'sd4242; cm_win = 8'd33;
    d_vc[3] = 10'd9; d_dim[3] = 8'd40;
    run_job(4'b1000, 0);

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int r;
        r = $urandom_range(0, 9);
        d_vc[i]  = 10'($urandom_range(1, MAX_VEC));
        d_dim[i] = 8'(8 * $urandom_range(1, 31));
        if (r == 0) d_vc[i] = 10'd0;
        if (r == 1) d_vc[i] = 10'($urandom_range(MAX_VEC + 1, 1023));
        if (r == 2) d_dim[i] = d_dim[i] | 8'($urandom_range(1, 7));
        if (r == 3) d_dim[i] = 8'd0;
      end
      cm_dead  = ($urandom_range(0, 9) == 0);
      cm_len   = $urandom_range(1, 8);
      cm_score = $urandom;
      cm_win   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      run_job(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 4));
    end

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
